// File: rtl/stopwatch_core.sv
// BCD stopwatch counter with 2 or 3 two-digit fields (ss, mm, optional hh).
// Up/down counting gated by a one-cycle tick, per-digit adjust, lap capture and countdown expiry.
module stopwatch_core #(
  parameter int FIELDS   = 2,
  parameter int HOUR_MAX = 23
) (
  input  logic                  clk_c,
  input  logic                  reset_c,
  input  logic                  tick,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  mode_down,
  input  logic                  adj,
  input  logic [2:0]            sel,
  input  logic [3:0]            num,
  input  logic                  load,
  input  logic                  lap,
  output logic [8*FIELDS-1:0]   digits,
  output logic [8*FIELDS-1:0]   lap_digits,
  output logic                  running,
  output logic                  expired,
  output logic                  wrap
);

  localparam int D = 2 * FIELDS;
  localparam int W = 4 * D;
  localparam logic [3:0] HT = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HU = 4'(HOUR_MAX % 10);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_ADJ, ST_EXPIRED} state_t;

  state_t         state_reg;
  logic [W-1:0]   digits_reg;
  logic [W-1:0]   lap_reg;
  logic           running_reg;
  logic           expired_reg;
  logic           wrap_reg;

  logic [FIELDS-1:0] field_max;
  logic [FIELDS-1:0] field_zero;
  logic              all_zero;
  logic [W-1:0]      inc_digits;
  logic              inc_wrap;
  logic [W-1:0]      dec_digits;
  logic [W-1:0]      load_raw;
  logic [W-1:0]      load_digits;

  // Per-field maxima: 59 for seconds/minutes, HOUR_MAX for the hours field.
  genvar gi;
  generate
    for (gi = 0; gi < FIELDS; gi++) begin : g_field
      localparam logic [3:0] TMAX = (gi == 2) ? HT : 4'd5;
      localparam logic [3:0] UMAX = (gi == 2) ? HU : 4'd9;
      assign field_max[gi]  = (digits_reg[gi*8+4 +: 4] == TMAX) &&
                              (digits_reg[gi*8 +: 4] == UMAX);
      assign field_zero[gi] = (digits_reg[gi*8 +: 8] == 8'h00);
    end
  endgenerate

  assign all_zero = &field_zero;

  always_comb begin
    logic       carry;
    logic [3:0] u;
    logic [3:0] t;
    inc_digits = digits_reg;
    carry      = 1'b1;
    u          = 4'd0;
    t          = 4'd0;
    for (int f = 0; f < FIELDS; f++) begin
      u = digits_reg[f*8 +: 4];
      t = digits_reg[f*8+4 +: 4];
      if (carry) begin
        if (field_max[f]) begin
          u = 4'd0;
          t = 4'd0;
        end else if (u == 4'd9) begin
          u     = 4'd0;
          t     = t + 4'd1;
          carry = 1'b0;
        end else begin
          u     = u + 4'd1;
          carry = 1'b0;
        end
      end
      inc_digits[f*8 +: 8] = {t, u};
    end
    inc_wrap = carry;
  end

  // A zero field borrows from above and reloads its own maximum.
  always_comb begin
    logic       borrow;
    logic [3:0] u;
    logic [3:0] t;
    dec_digits = digits_reg;
    borrow     = 1'b1;
    u          = 4'd0;
    t          = 4'd0;
    for (int f = 0; f < FIELDS; f++) begin
      u = digits_reg[f*8 +: 4];
      t = digits_reg[f*8+4 +: 4];
      if (borrow) begin
        if (field_zero[f]) begin
          t = (f == 2) ? HT : 4'd5;
          u = (f == 2) ? HU : 4'd9;
        end else if (u == 4'd0) begin
          u      = 4'd9;
          t      = t - 4'd1;
          borrow = 1'b0;
        end else begin
          u      = u - 4'd1;
          borrow = 1'b0;
        end
      end
      dec_digits[f*8 +: 8] = {t, u};
    end
  end

  always_comb begin
    logic [3:0] lim;
    load_raw = digits_reg;
    lim      = 4'd9;
    for (int i = 0; i < D; i++) begin
      if (sel == 3'(i)) begin
        lim = (((i % 2) == 0) || ((i / 2) == 2)) ? 4'd9 : 4'd5;
        load_raw[i*4 +: 4] = (num > lim) ? lim : num;
      end
    end
  end

  // Hours written digit-by-digit can exceed HOUR_MAX (e.g. 2 then 9); clamp the whole field.
  generate
    if (FIELDS == 3) begin : g_hour_clamp
      logic [6:0] hour_val;
      assign hour_val    = 7'(load_raw[23:20]) * 7'd10 + 7'(load_raw[19:16]);
      assign load_digits = (hour_val > 7'(HOUR_MAX)) ? {HT, HU, load_raw[15:0]} : load_raw;
    end else begin : g_no_hours
      assign load_digits = load_raw;
    end
  endgenerate

  always_ff @(posedge clk_c or negedge reset_c) begin
    if (!reset_c) begin
      state_reg   <= ST_STOP;
      digits_reg  <= '0;
      lap_reg     <= '0;
      running_reg <= 1'b0;
      expired_reg <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (lap)
        lap_reg <= digits_reg;
      if (clear) begin
        state_reg   <= ST_STOP;
        digits_reg  <= '0;
        running_reg <= 1'b0;
        expired_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_STOP: begin
            if (adj) begin
              state_reg <= ST_ADJ;
            end else if (start_stop && !(mode_down && all_zero)) begin
              state_reg   <= ST_RUN;
              running_reg <= 1'b1;
            end
          end
          ST_RUN: begin
            if (adj) begin
              state_reg   <= ST_ADJ;
              running_reg <= 1'b0;
            end else if (start_stop) begin
              state_reg   <= ST_STOP;
              running_reg <= 1'b0;
            end else if (tick) begin
              if (mode_down) begin
                if (all_zero) begin
                  state_reg   <= ST_EXPIRED;
                  running_reg <= 1'b0;
                  expired_reg <= 1'b1;
                end else begin
                  digits_reg <= dec_digits;
                end
              end else begin
                digits_reg <= inc_digits;
                wrap_reg   <= inc_wrap;
              end
            end
          end
          ST_ADJ: begin
            if (!adj)
              state_reg <= ST_STOP;
            else if (load)
              digits_reg <= load_digits;
          end
          ST_EXPIRED: begin
            if (start_stop) begin
              state_reg   <= ST_STOP;
              expired_reg <= 1'b0;
            end
          end
          default: state_reg <= ST_STOP;
        endcase
      end
    end
  end

  assign digits     = digits_reg;
  assign lap_digits = lap_reg;
  assign running    = running_reg;
  assign expired    = expired_reg;
  assign wrap       = wrap_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a 2-field and a 3-field instance share one stimulus set.
module tb_stopwatch_core;

  logic        clk_c = 1'b0;
  logic        reset_c = 1'b0;
  logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0, mode_down = 1'b0;
  logic        adj = 1'b0, load = 1'b0, lap = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [3:0]  num = 4'd0;

  logic [15:0] d2, lap2;
  logic        run2, exp2, wrap2;
  logic [23:0] d3, lap3;
  logic        run3, exp3, wrap3;

  int checks = 0;
  int failures = 0;

  always #5 clk_c = ~clk_c;

  stopwatch_core #(.FIELDS(2), .HOUR_MAX(23)) u2 (
    .clk_c(clk_c), .reset_c(reset_c), .tick(tick), .start_stop(start_stop),
    .clear(clear), .mode_down(mode_down), .adj(adj), .sel(sel), .num(num),
    .load(load), .lap(lap), .digits(d2), .lap_digits(lap2),
    .running(run2), .expired(exp2), .wrap(wrap2));

  stopwatch_core #(.FIELDS(3), .HOUR_MAX(23)) u3 (
    .clk_c(clk_c), .reset_c(reset_c), .tick(tick), .start_stop(start_stop),
    .clear(clear), .mode_down(mode_down), .adj(adj), .sel(sel), .num(num),
    .load(load), .lap(lap), .digits(d3), .lap_digits(lap3),
    .running(run3), .expired(exp3), .wrap(wrap3));

  task automatic cyc();
    @(posedge clk_c);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] s, input logic [3:0] n);
    sel = s; num = n; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic do_start();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (d2 !== 16'h0 || lap2 !== 16'h0 || run2 !== 1'b0 || exp2 !== 1'b0 || wrap2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_f2: got d=%h lap=%h r=%b e=%b w=%b want all 0", d2, lap2, run2, exp2, wrap2);
    end
    checks++;
    if (d3 !== 24'h0 || lap3 !== 24'h0 || run3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_f3: got d=%h lap=%h r=%b want all 0", d3, lap3, run3);
    end
    cyc(); cyc();
    reset_c = 1'b1;
    cyc();
  endtask

  task automatic test_up_wrap();
    do_clear();
    adj = 1'b1; cyc();
    do_load(3'd0, 4'd8); do_load(3'd1, 4'd5); do_load(3'd2, 4'd9); do_load(3'd3, 4'd5);
    adj = 1'b0; cyc();
    checks++;
    if (d2 !== 16'h5958) begin failures++; $display("FAIL up_preload: got %h want 5958", d2); end
    do_start();
    checks++;
    if (run2 !== 1'b1) begin failures++; $display("FAIL up_running: got %b want 1", run2); end
    tick = 1'b1; cyc();
    checks++;
    if (d2 !== 16'h5959 || wrap2 !== 1'b0) begin
      failures++; $display("FAIL up_tick1: got %h w=%b want 5959 w=0", d2, wrap2);
    end
    cyc(); tick = 1'b0;
    checks++;
    if (d2 !== 16'h0000 || wrap2 !== 1'b1 || run2 !== 1'b1) begin
      failures++; $display("FAIL up_wrap: got %h w=%b r=%b want 0000 w=1 r=1", d2, wrap2, run2);
    end
    cyc();
    checks++;
    if (wrap2 !== 1'b0 || d2 !== 16'h0000) begin
      failures++; $display("FAIL up_wrap_pulse: got w=%b d=%h want w=0 d=0000", wrap2, d2);
    end
  endtask

  task automatic test_hours();
    do_clear();
    adj = 1'b1; cyc();
    do_load(3'd5, 4'd2);
    checks++;
    if (d3[23:16] !== 8'h20) begin failures++; $display("FAIL hour_tens: got %h want 20", d3[23:16]); end
    do_load(3'd4, 4'd9);
    checks++;
    if (d3[23:16] !== 8'h23) begin failures++; $display("FAIL hour_clamp: got %h want 23", d3[23:16]); end
    do_load(3'd0, 4'd9); do_load(3'd1, 4'd5); do_load(3'd2, 4'd9); do_load(3'd3, 4'd5);
    adj = 1'b0; cyc();
    checks++;
    if (d3 !== 24'h235959) begin failures++; $display("FAIL hour_preload: got %h want 235959", d3); end
    do_start();
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (d3 !== 24'h000000 || wrap3 !== 1'b1) begin
      failures++; $display("FAIL hour_wrap: got %h w=%b want 000000 w=1", d3, wrap3);
    end
    do_start();
  endtask

  task automatic test_down_expire();
    do_clear();
    mode_down = 1'b1;
    do_start();
    checks++;
    if (run2 !== 1'b0) begin failures++; $display("FAIL down_zero_start: got r=%b want 0", run2); end
    adj = 1'b1; cyc();
    do_load(3'd2, 4'd1);
    adj = 1'b0; cyc();
    do_start();
    tick = 1'b1; cyc();
    checks++;
    if (d2 !== 16'h0059) begin failures++; $display("FAIL down_borrow: got %h want 0059", d2); end
    for (int i = 1; i < 60; i++) cyc();
    tick = 1'b0;
    checks++;
    if (d2 !== 16'h0000 || exp2 !== 1'b0 || run2 !== 1'b1) begin
      failures++; $display("FAIL down_zero: got %h e=%b r=%b want 0000 e=0 r=1", d2, exp2, run2);
    end
    checks++;
    if (d3 !== 24'h000000) begin failures++; $display("FAIL down_zero_f3: got %h want 000000", d3); end
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (exp2 !== 1'b1 || run2 !== 1'b0 || d2 !== 16'h0000) begin
      failures++; $display("FAIL down_expire: got e=%b r=%b d=%h want e=1 r=0 d=0000", exp2, run2, d2);
    end
    cyc();
    checks++;
    if (exp2 !== 1'b1) begin failures++; $display("FAIL expire_hold: got %b want 1", exp2); end
    do_start();
    checks++;
    if (exp2 !== 1'b0 || run2 !== 1'b0) begin
      failures++; $display("FAIL expire_exit: got e=%b r=%b want 0 0", exp2, run2);
    end
    mode_down = 1'b0;
  endtask

  task automatic test_lap();
    do_clear();
    adj = 1'b1; cyc();
    do_load(3'd0, 4'd5);
    adj = 1'b0; cyc();
    do_start();
    tick = 1'b1; lap = 1'b1; cyc(); tick = 1'b0; lap = 1'b0;
    checks++;
    if (lap2 !== 16'h0005 || d2 !== 16'h0006) begin
      failures++; $display("FAIL lap_tick: got lap=%h d=%h want lap=0005 d=0006", lap2, d2);
    end
    do_clear();
    checks++;
    if (d2 !== 16'h0000 || lap2 !== 16'h0005 || run2 !== 1'b0) begin
      failures++; $display("FAIL lap_clear: got d=%h lap=%h r=%b want 0000 0005 0", d2, lap2, run2);
    end
  endtask

  task automatic test_adjust();
    do_clear();
    adj = 1'b1; cyc();
    do_load(3'd1, 4'd9);
    checks++;
    if (d2 !== 16'h0050) begin failures++; $display("FAIL adj_tens_clamp: got %h want 0050", d2); end
    do_load(3'd0, 4'd15);
    checks++;
    if (d2 !== 16'h0059) begin failures++; $display("FAIL adj_unit_clamp: got %h want 0059", d2); end
    do_load(3'd7, 4'd3);
    do_load(3'd4, 4'd3);
    checks++;
    if (d2 !== 16'h0059) begin failures++; $display("FAIL adj_sel_range: got %h want 0059", d2); end
    tick = 1'b1; cyc(); cyc(); tick = 1'b0;
    checks++;
    if (d2 !== 16'h0059 || run2 !== 1'b0) begin
      failures++; $display("FAIL adj_tick_ignored: got %h r=%b want 0059 r=0", d2, run2);
    end
    adj = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (d2 !== 16'h0059 || run2 !== 1'b0) begin
      failures++; $display("FAIL adj_exit_stop: got %h r=%b want 0059 r=0", d2, run2);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    adj = 1'b1; cyc();
    do_load(3'd0, 4'd4); do_load(3'd1, 4'd3); do_load(3'd2, 4'd2); do_load(3'd3, 4'd1);
    adj = 1'b0; cyc();
    do_start();
    checks++;
    if (d2 !== 16'h1234 || run2 !== 1'b1) begin
      failures++; $display("FAIL rst_preload: got %h r=%b want 1234 r=1", d2, run2);
    end
    #2 reset_c = 1'b0;
    #1;
    checks++;
    if (d2 !== 16'h0 || run2 !== 1'b0 || lap2 !== 16'h0) begin
      failures++; $display("FAIL rst_async: got d=%h r=%b lap=%h want 0 0 0", d2, run2, lap2);
    end
    cyc();
    reset_c = 1'b1;
    tick = 1'b1; cyc(); cyc(); cyc(); tick = 1'b0;
    checks++;
    if (d2 !== 16'h0 || run2 !== 1'b0) begin
      failures++; $display("FAIL rst_idle: got d=%h r=%b want 0000 r=0", d2, run2);
    end
    do_start();
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (d2 !== 16'h0001 || run2 !== 1'b1) begin
      failures++; $display("FAIL rst_resume: got d=%h r=%b want 0001 r=1", d2, run2);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_hours();
    test_down_expire();
    test_lap();
    test_adjust();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
